// File: rtl/jtag_dbg_regbank.sv
// Addressable bank of debug control/status registers behind a single JTAG DEBUG data register.
// Optional macro DBG_REGBANK_AUTOINC_EN enables address auto-increment and all-ones burst access.
module jtag_dbg_regbank #(
  parameter int unsigned NUM_CTRL = 4,
  parameter int unsigned NUM_STAT = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                         tck_i,
  input  logic                         trst_n_i,
  input  logic                         capture_dr_i,
  input  logic                         shift_dr_i,
  input  logic                         update_dr_i,
  input  logic                         select_i,
  input  logic                         tdi_i,
  output logic                         tdo_o,
  input  logic [NUM_STAT*DATA_W-1:0]   stat_i,
  output logic [NUM_CTRL*DATA_W-1:0]   ctrl_o,
  output logic                         wr_valid_o,
  output logic [ADDR_W-1:0]            wr_addr_o,
  input  logic                         wr_ready_i
);

  localparam int unsigned DR_LEN   = DATA_W + ADDR_W + 2;
  localparam int unsigned NUM_REGS = NUM_CTRL + NUM_STAT;

  localparam logic [1:0] OpNop    = 2'b00;
  localparam logic [1:0] OpRead   = 2'b01;
  localparam logic [1:0] OpWrite  = 2'b10;
  localparam logic [1:0] OpClrErr = 2'b11;

  typedef enum logic {StIdle, StWrPend} wr_state_e;

  wr_state_e          state_q, state_d;
  logic [DR_LEN-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  rd_q, rd_d;
  logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic               err_q, err_d;
  logic               ovr_q, ovr_d;
  logic [DATA_W-1:0]  ctrl_q [NUM_CTRL];
  logic [DATA_W-1:0]  ctrl_d [NUM_CTRL];

  logic [DATA_W-1:0]  upd_data;
  logic [ADDR_W-1:0]  upd_addr;
  logic [1:0]         upd_op;
  logic [ADDR_W-1:0]  tgt_addr;
  logic [ADDR_W-1:0]  ok_last_addr;
  logic [31:0]        tgt_idx;
  logic               tgt_is_ctrl;
  logic               tgt_is_valid;
  logic [DATA_W-1:0]  rd_sel;

  assign upd_data = shift_q[DATA_W-1:0];
  assign upd_addr = shift_q[DATA_W +: ADDR_W];
  assign upd_op   = shift_q[DR_LEN-1 -: 2];

`ifdef DBG_REGBANK_AUTOINC_EN
  // All-ones address field means "continue from where the last access left off".
  assign tgt_addr = (upd_addr == {ADDR_W{1'b1}}) ? last_addr_q : upd_addr;
  assign ok_last_addr = (tgt_idx == NUM_REGS - 1) ? '0 : tgt_addr + ADDR_W'(1);
`else
  assign tgt_addr     = upd_addr;
  assign ok_last_addr = upd_addr;
`endif

  assign tgt_idx      = 32'(tgt_addr);
  assign tgt_is_ctrl  = tgt_idx < NUM_CTRL;
  assign tgt_is_valid = tgt_idx < NUM_REGS;

  always_comb begin
    rd_sel = '0;
    for (int unsigned k = 0; k < NUM_CTRL; k++) begin
      if (tgt_idx == k) rd_sel = ctrl_q[k];
    end
    for (int unsigned k = 0; k < NUM_STAT; k++) begin
      if (tgt_idx == NUM_CTRL + k) rd_sel = stat_i[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    rd_d        = rd_q;
    last_addr_d = last_addr_q;
    wr_addr_d   = wr_addr_q;
    err_d       = err_q;
    ovr_d       = ovr_q;
    ctrl_d      = ctrl_q;

    // Handshake completes independently of select_i.
    if (state_q == StWrPend && wr_ready_i) state_d = StIdle;

    if (select_i) begin
      if (capture_dr_i) begin
        shift_d = {err_q | ovr_q, state_q == StWrPend, last_addr_q, rd_q};
      end else if (shift_dr_i) begin
        shift_d = {tdi_i, shift_q[DR_LEN-1:1]};
      end else if (update_dr_i) begin
        if (upd_op != OpNop) last_addr_d = tgt_addr;
        unique case (upd_op)
          OpRead: begin
            if (tgt_is_valid) begin
              rd_d        = rd_sel;
              last_addr_d = ok_last_addr;
            end else begin
              rd_d  = '0;
              err_d = 1'b1;
            end
          end
          OpWrite: begin
            if (!tgt_is_ctrl) begin
              err_d = 1'b1;
            end else if (state_q == StWrPend) begin
              // Still pending even if the ready edge coincides: drop and flag overrun.
              ovr_d = 1'b1;
            end else begin
              for (int unsigned k = 0; k < NUM_CTRL; k++) begin
                if (tgt_idx == k) ctrl_d[k] = upd_data;
              end
              wr_addr_d   = tgt_addr;
              state_d     = StWrPend;
              last_addr_d = ok_last_addr;
            end
          end
          OpClrErr: begin
            err_d = 1'b0;
            ovr_d = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      rd_q        <= '0;
      last_addr_q <= '0;
      wr_addr_q   <= '0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      ctrl_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      rd_q        <= rd_d;
      last_addr_q <= last_addr_d;
      wr_addr_q   <= wr_addr_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
      ctrl_q      <= ctrl_d;
    end
  end

  for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl_out
    assign ctrl_o[k*DATA_W +: DATA_W] = ctrl_q[k];
  end

  assign tdo_o      = select_i & shift_q[0];
  assign wr_valid_o = (state_q == StWrPend);
  assign wr_addr_o  = wr_addr_q;

endmodule
